// File: rtl/vm_pkg.sv
// Shared coin-bus definitions for the vending machine
// and its customer-side sequencer.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;

  localparam int VAL_FIVE  = 5;
  localparam int VAL_TEN   = 10;
  localparam int DEF_PRICE = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } seq_state_t;

  function automatic logic [4:0] coin_value(
    input logic [1:0] c
  );
    logic [4:0] v;
    v = '0;
    unique case (1'b1)
      c == COIN_FIVE: v = 5'(VAL_FIVE);
      c == COIN_TEN:  v = 5'(VAL_TEN);
      default:        v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_credit_mirror.sv
// Tracks machine credit and predicts the Mealy
// product/change response to the next coin.
module vm_credit_mirror
  import vm_pkg::*;
#(
  parameter int PRICE = DEF_PRICE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       apply,
  input  logic [4:0] value,
  output logic [4:0] credit_nxt,
  output logic       exp_product,
  output logic       exp_change
);

  logic [4:0] credit;
  logic [5:0] sum;

  assign sum = {1'b0, credit} + {1'b0, value};
  assign exp_product = sum >= 6'(PRICE);
  assign exp_change  = sum >  6'(PRICE);
  assign credit_nxt  = exp_product ? '0 : sum[4:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else if (clear) begin
      credit <= '0;
    end else if (apply) begin
      credit <= credit_nxt;
    end
  end

endmodule

// File: rtl/coin_sequencer.sv
// Customer-side coin driver: issues a purse of coins
// and checks the machine's vend/change responses.
module coin_sequencer
  import vm_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int GAP    = 0,
  parameter int PRICE  = DEF_PRICE,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_five,
  input  logic [CNT_W-1:0]  num_ten,
  input  logic              tens_first,
  input  logic              product,
  input  logic              change,
  output logic [1:0]        coin,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] vend_count,
  output logic [STAT_W-1:0] change_count,
  output logic [4:0]        residue,
  output logic              mismatch
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  seq_state_t       state;
  logic [CNT_W-1:0] nf;
  logic [CNT_W-1:0] nt;
  logic             order;
  logic [GW-1:0]    gcnt;

  logic             accept;
  logic [CNT_W-1:0] nf_dec;
  logic [CNT_W-1:0] nt_dec;
  logic             more;
  logic [4:0]       credit_nxt;
  logic             exp_product;
  logic             exp_change;
  logic             bad_issue;
  logic             stray;

  function automatic logic [1:0] pick(
    input logic             tf,
    input logic [CNT_W-1:0] f,
    input logic [CNT_W-1:0] t
  );
    if (tf) return (t != '0) ? COIN_TEN : COIN_FIVE;
    return (f != '0) ? COIN_FIVE : COIN_TEN;
  endfunction

  assign accept = (state == IDLE) && start;
  assign nf_dec = nf - CNT_W'(coin == COIN_FIVE);
  assign nt_dec = nt - CNT_W'(coin == COIN_TEN);
  assign more   = (nf_dec != '0) || (nt_dec != '0);

  assign bad_issue = (product != exp_product) ||
                     (change  != exp_change);
  assign stray     = product || change;

  vm_credit_mirror #(
    .PRICE(PRICE)
  ) u_mirror (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .apply      (state == ISSUE),
    .value      (coin_value(coin)),
    .credit_nxt (credit_nxt),
    .exp_product(exp_product),
    .exp_change (exp_change)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      coin         <= COIN_NONE;
      busy         <= 1'b0;
      done         <= 1'b0;
      nf           <= '0;
      nt           <= '0;
      order        <= 1'b0;
      gcnt         <= '0;
      vend_count   <= '0;
      change_count <= '0;
      residue      <= '0;
      mismatch     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nf           <= num_five;
            nt           <= num_ten;
            order        <= tens_first;
            vend_count   <= '0;
            change_count <= '0;
            residue      <= '0;
            mismatch     <= 1'b0;
            busy         <= 1'b1;
            if (num_five == '0 && num_ten == '0) begin
              state <= FINISH;
              coin  <= COIN_NONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              coin  <= pick(tens_first, num_five, num_ten);
            end
          end
        end
        ISSUE: begin
          nf <= nf_dec;
          nt <= nt_dec;
          if (product && vend_count != '1)
            vend_count <= vend_count + STAT_W'(1);
          if (change && change_count != '1)
            change_count <= change_count + STAT_W'(1);
          if (bad_issue)
            mismatch <= 1'b1;
          if (!more) begin
            state   <= FINISH;
            coin    <= COIN_NONE;
            done    <= 1'b1;
            residue <= credit_nxt;
          end else if (GAP > 0) begin
            state <= WAIT;
            coin  <= COIN_NONE;
            gcnt  <= GW'(GAP - 1);
          end else begin
            coin <= pick(order, nf_dec, nt_dec);
          end
        end
        WAIT: begin
          if (stray)
            mismatch <= 1'b1;
          if (gcnt == '0) begin
            state <= ISSUE;
            coin  <= pick(order, nf, nt);
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        FINISH: begin
          if (stray)
            mismatch <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_sequencer.sv
// Randomized self-checking bench for coin_sequencer
// against a per-cycle purse model.
module tb_coin_sequencer;

  localparam int PRICE = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start2 = 1'b0;
  logic [3:0] num_five = '0;
  logic [3:0] num_ten = '0;
  logic       tens_first = 1'b0;
  logic       p0 = 1'b0, c0 = 1'b0;
  logic       p2 = 1'b0, c2 = 1'b0;

  logic [1:0] coin0, coin2;
  logic       busy0, busy2, done0, done2;
  logic [7:0] vend0, vend2, chg0, chg2;
  logic [4:0] res0, res2;
  logic       mm0, mm2;

  always #5 clk = ~clk;

  coin_sequencer #(
    .CNT_W(4), .GAP(0), .PRICE(PRICE), .STAT_W(8)
  ) u_g0 (
    .clk(clk), .rst(rst), .start(start0),
    .num_five(num_five), .num_ten(num_ten),
    .tens_first(tens_first),
    .product(p0), .change(c0),
    .coin(coin0), .busy(busy0), .done(done0),
    .vend_count(vend0), .change_count(chg0),
    .residue(res0), .mismatch(mm0)
  );

  coin_sequencer #(
    .CNT_W(4), .GAP(2), .PRICE(PRICE), .STAT_W(8)
  ) u_g2 (
    .clk(clk), .rst(rst), .start(start2),
    .num_five(num_five), .num_ten(num_ten),
    .tens_first(tens_first),
    .product(p2), .change(c2),
    .coin(coin2), .busy(busy2), .done(done2),
    .vend_count(vend2), .change_count(chg2),
    .residue(res2), .mismatch(mm2)
  );

  int n_err = 0;
  int n_checks = 0;

  bit chk_en = 1'b0;
  bit sel = 1'b0;
  bit e_rv = 1'b0;
  int e_coin, e_busy, e_done;
  int e_vend, e_chg, e_res, e_mm;

  // per-cycle purse plan: 0 coin, 1 gap, 2 finish
  int kind[128], val[128];
  int cp[128], cc[128], dp[128], dc[128];
  int n_cyc, m_res;
  int last_v[2], last_c[2], last_r[2], last_m[2];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("coin", sel ? coin2 : coin0, e_coin);
      chk("busy", sel ? busy2 : busy0, e_busy);
      chk("done", sel ? done2 : done0, e_done);
      chk("vend", sel ? vend2 : vend0, e_vend);
      chk("chg", sel ? chg2 : chg0, e_chg);
      chk("mismatch", sel ? mm2 : mm0, e_mm);
      if (e_rv) chk("residue", sel ? res2 : res0, e_res);
    end
  end

  task automatic drive(input bit p, input bit c);
    p0 = sel ? 1'b0 : p;
    c0 = sel ? 1'b0 : c;
    p2 = sel ? p : 1'b0;
    c2 = sel ? c : 1'b0;
  endtask

  task automatic build(input int nf, input int nt,
                       input bit tf, input int gap,
                       input int fm);
    int vals[$];
    int credit;
    vals.delete();
    if (tf) begin
      repeat (nt) vals.push_back(10);
      repeat (nf) vals.push_back(5);
    end else begin
      repeat (nf) vals.push_back(5);
      repeat (nt) vals.push_back(10);
    end
    n_cyc = 0;
    credit = 0;
    foreach (vals[i]) begin
      int s;
      s = credit + vals[i];
      kind[n_cyc] = 0;
      val[n_cyc] = vals[i];
      cp[n_cyc] = (s >= PRICE) ? 1 : 0;
      cc[n_cyc] = (s > PRICE) ? 1 : 0;
      credit = (s >= PRICE) ? 0 : s;
      dp[n_cyc] = cp[n_cyc];
      dc[n_cyc] = cc[n_cyc];
      if (fm == 1) dp[n_cyc] = 0;
      if (fm == 2) begin
        if ($urandom_range(0, 5) == 0) dp[n_cyc] ^= 1;
        if ($urandom_range(0, 5) == 0) dc[n_cyc] ^= 1;
      end
      n_cyc++;
      if (i != vals.size() - 1) begin
        repeat (gap) begin
          kind[n_cyc] = 1;
          cp[n_cyc] = 0;
          cc[n_cyc] = 0;
          dp[n_cyc] = 0;
          dc[n_cyc] = 0;
          if (fm == 2 && $urandom_range(0, 9) == 0)
            dp[n_cyc] = 1;
          n_cyc++;
        end
      end
    end
    kind[n_cyc] = 2;
    cp[n_cyc] = 0;
    cc[n_cyc] = 0;
    dp[n_cyc] = 0;
    dc[n_cyc] = 0;
    if (fm == 2 && $urandom_range(0, 9) == 0)
      dc[n_cyc] = 1;
    n_cyc++;
    m_res = credit;
  endtask

  task automatic run_purse(input bit s, input int nf,
                           input int nt, input bit tf,
                           input int fm, input int pulse_at);
    int av, ac, am;
    int e;
    build(nf, nt, tf, s ? 2 : 0, fm);
    @(posedge clk);
    #1;
    sel = s;
    num_five = 4'(nf);
    num_ten = 4'(nt);
    tens_first = tf;
    start0 = !s;
    start2 = s;
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    e_coin = 0; e_busy = 0; e_done = 0;
    e_vend = last_v[s]; e_chg = last_c[s];
    e_mm = last_m[s]; e_res = last_r[s]; e_rv = 1'b1;
    chk_en = 1'b1;
    av = 0; ac = 0; am = 0;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk);
      #1;
      e = k - 1;
      start0 = 1'b0;
      start2 = 1'b0;
      num_five = 4'($urandom);
      num_ten = 4'($urandom);
      tens_first = 1'($urandom);
      if (k == pulse_at) begin
        start0 = !s;
        start2 = s;
      end
      drive(1'(dp[e]), 1'(dc[e]));
      e_coin = (kind[e] != 0) ? 0 : (val[e] == 5 ? 1 : 2);
      e_busy = 1;
      e_done = (kind[e] == 2) ? 1 : 0;
      e_vend = av; e_chg = ac; e_mm = am;
      e_rv = (kind[e] == 2);
      e_res = m_res;
      if (kind[e] == 0) begin
        av += dp[e];
        ac += dc[e];
        if (dp[e] != cp[e] || dc[e] != cc[e]) am = 1;
      end else if (dp[e] != 0 || dc[e] != 0) begin
        am = 1;
      end
    end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    e_coin = 0; e_busy = 0; e_done = 0;
    e_vend = av; e_chg = ac; e_mm = am;
    e_res = m_res; e_rv = 1'b1;
    last_v[s] = av; last_c[s] = ac;
    last_m[s] = am; last_r[s] = m_res;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      last_v[i] = 0; last_c[i] = 0;
      last_m[i] = 0; last_r[i] = 0;
    end
    #1;
    chk("rst_coin0", coin0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_vend2", vend2, 0);
    chk("rst_mm2", mm2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // five, five, five: vend on the third
    run_purse(0, 3, 0, 0, 0, 0);
    chk("t2_vend", vend0, 1);
    chk("t2_chg", chg0, 0);
    chk("t2_res", res0, 0);

    // ten, ten (vend+change), five left over
    run_purse(0, 1, 2, 1, 0, 0);
    chk("t3_vend", vend0, 1);
    chk("t3_chg", chg0, 1);
    chk("t3_res", res0, 5);

    // asynchronous reset mid-purse
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    sel = 1'b0;
    drive(1'b0, 1'b0);
    num_five = 4'd3;
    num_ten = 4'd0;
    tens_first = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("pre_rst_coin", coin0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_coin", coin0, 0);
    chk("async_busy", busy0, 0);
    chk("async_done", done0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_vend", vend0, 0);
    chk("post_rst_chg", chg0, 0);
    chk("post_rst_res", res0, 0);
    chk("post_rst_busy", busy0, 0);
    for (int i = 0; i < 2; i++) begin
      last_v[i] = 0; last_c[i] = 0;
      last_m[i] = 0; last_r[i] = 0;
    end

    // GAP=2: 5,-,-,5,-,-,10 then finish
    run_purse(1, 2, 1, 0, 0, 0);
    chk("t4_len", n_cyc, 8);
    chk("t4_vend", vend2, 1);
    chk("t4_chg", chg2, 1);
    chk("t4_res", res2, 0);

    // empty purse
    run_purse(0, 0, 0, 0, 0, 0);
    chk("t5_vend", vend0, 0);
    chk("t5_busy", busy0, 0);

    // responder never vends; restart attempt mid-purse
    run_purse(0, 3, 0, 0, 1, 2);
    chk("t6_mm", mm0, 1);
    chk("t6_vend", vend0, 0);
    run_purse(0, 2, 0, 0, 0, 0);
    chk("t6_clear", mm0, 0);

    for (int t = 0; t < 40; t++) begin
      int nf, nt, fm;
      nf = $urandom_range(0, 6);
      nt = $urandom_range(0, 6);
      if (t % 10 == 9) begin
        nf = 15;
        nt = $urandom_range(10, 15);
      end
      fm = ($urandom_range(0, 3) == 0) ? 2 : 0;
      run_purse(1'($urandom_range(0, 1)), nf, nt,
                1'($urandom_range(0, 1)), fm,
                $urandom_range(0, 6));
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_checks);
    $finish;
  end

endmodule
